// File: rtl/aug_pkg.sv
// Shared types and default constants for the augmentation parameter generator.
// Optional seed-load feature of the generator is enabled by defining LFSR_SEED_LOAD_EN.
package aug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } aug_state_e;

  localparam logic [15:0] DEFAULT_TAP_MASK_16 = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED_16     = 16'h0121;

  // Counter width helper: never returns zero so single-entry counters stay legal.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lfsr_xnor_core.sv
// XNOR Fibonacci LFSR register with step/load controls and an all-ones lockup guard.
// next_state is the guarded result of one shift, so callers can use it as the draw candidate.
module lfsr_xnor_core
  import aug_pkg::*;
#(
  parameter int           W        = 16,
  parameter logic [W-1:0] TAP_MASK = W'(DEFAULT_TAP_MASK_16),
  parameter logic [W-1:0] SEED     = W'(DEFAULT_SEED_16)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] cur_state,
  output logic [W-1:0] next_state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] shifted;
  logic [W-1:0] load_guarded;
  logic         fb;

  // All-ones is the XNOR lockup state; any attempt to enter it falls back to SEED.
  always_comb begin
    fb           = ~(^(state_q & TAP_MASK));
    shifted      = {fb, state_q[W-1:1]};
    next_state   = (&shifted) ? SEED : shifted;
    load_guarded = (&load_value) ? SEED : load_value;
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_guarded;
    end else if (step) begin
      state_d = next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign cur_state = state_q;

endmodule

// File: rtl/lfsr_aug_param_gen.sv
// Draws NUM_CH bounded random values per request by rejection sampling an XNOR LFSR.
// Define LFSR_SEED_LOAD_EN to add seed_load/seed_value for reseeding while idle.
module lfsr_aug_param_gen
  import aug_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAP_MASK  = LFSR_W'(DEFAULT_TAP_MASK_16),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED_16),
  parameter int                NUM_CH    = 3,
  parameter int                OUT_W     = 4,
  parameter int                MAX_TRIES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NUM_CH*OUT_W-1:0] limit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] values,
  output logic [NUM_CH-1:0]       fallback
`ifdef LFSR_SEED_LOAD_EN
  ,
  input  logic                    seed_load,
  input  logic [LFSR_W-1:0]       seed_value
`endif
);

  localparam int CH_W  = clog2_min1(NUM_CH);
  localparam int TRY_W = clog2_min1(MAX_TRIES);

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  aug_state_e                state_q, state_d;
  logic [NUM_CH*OUT_W-1:0]   limit_q, limit_d;
  logic [NUM_CH*OUT_W-1:0]   values_q, values_d;
  logic [NUM_CH-1:0]         fallback_q, fallback_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [TRY_W-1:0]          tries_q, tries_d;

  logic                      lfsr_step;
  logic                      lfsr_load;
  logic [LFSR_W-1:0]         lfsr_load_value;
  logic [LFSR_W-1:0]         lfsr_cur;
  logic [LFSR_W-1:0]         lfsr_next;
  logic                      seed_load_req;

  logic [OUT_W-1:0]          lim_arr [NUM_CH];
  logic [OUT_W-1:0]          cand;
  logic [OUT_W-1:0]          cur_limit;
  logic                      ch_done;

  // Latched limits unpacked per channel so the compare can index by ch_q.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lim
    assign lim_arr[gi] = limit_q[gi*OUT_W +: OUT_W];
  end

`ifdef LFSR_SEED_LOAD_EN
  assign seed_load_req   = seed_load && (state_q == IDLE);
  assign lfsr_load_value = seed_value;
`else
  assign seed_load_req   = 1'b0;
  assign lfsr_load_value = '0;
`endif

  lfsr_xnor_core #(
    .W        (LFSR_W),
    .TAP_MASK (TAP_MASK),
    .SEED     (SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step       (lfsr_step),
    .load       (lfsr_load),
    .load_value (lfsr_load_value),
    .cur_state  (lfsr_cur),
    .next_state (lfsr_next)
  );

  // The current state is only observed through next_state; keep lint quiet about it.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^{lfsr_cur, lfsr_next};

  assign cand      = lfsr_next[OUT_W-1:0];
  assign cur_limit = lim_arr[ch_q];
  assign req_ready = (state_q == IDLE) && !seed_load_req;
  assign out_valid = (state_q == DONE);
  assign values    = values_q;
  assign fallback  = fallback_q;

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    values_d   = values_q;
    fallback_d = fallback_q;
    ch_d       = ch_q;
    tries_d    = tries_q;
    lfsr_step  = 1'b0;
    lfsr_load  = 1'b0;
    ch_done    = 1'b0;

    case (state_q)
      IDLE: begin
        lfsr_load = seed_load_req;
        if (req_valid && req_ready) begin
          limit_d    = limit;
          ch_d       = '0;
          tries_d    = '0;
          fallback_d = '0;
          state_d    = DRAW;
        end
      end

      DRAW: begin
        lfsr_step = 1'b1;
        if (cand <= cur_limit) begin
          values_d[ch_q*OUT_W +: OUT_W] = cand;
          ch_done = 1'b1;
        end else if (tries_q == LAST_TRY) begin
          values_d[ch_q*OUT_W +: OUT_W] = '0;
          fallback_d[ch_q]              = 1'b1;
          ch_done = 1'b1;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end

        if (ch_done) begin
          tries_d = '0;
          if (ch_q == LAST_CH) begin
            ch_d    = '0;
            state_d = DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      values_q   <= '0;
      fallback_q <= '0;
      ch_q       <= '0;
      tries_q    <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      values_q   <= values_d;
      fallback_q <= fallback_d;
      ch_q       <= ch_d;
      tries_q    <= tries_d;
    end
  end

endmodule

// File: tb/tb_lfsr_aug_param_gen.sv
// Directed scoreboard bench for lfsr_aug_param_gen (default parameters).
// Seed-load checks are included when LFSR_SEED_LOAD_EN is defined.
module tb_lfsr_aug_param_gen;

  localparam logic [15:0] M_SEED = 16'h0121;
  localparam logic [15:0] M_MASK = 16'hB400;

  typedef struct {
    logic [11:0] vals;
    logic [2:0]  fb;
    int          draws;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] limit;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] values;
  logic [2:0]  fallback;
`ifdef LFSR_SEED_LOAD_EN
  logic        seed_load;
  logic [15:0] seed_value;
`endif

  exp_t        sb_q[$];
  logic [15:0] m_lfsr;
  int          total;
  int          bad;
  logic [11:0] first_vals;
  logic [11:0] last_limit;

  lfsr_aug_param_gen dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .limit      (limit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .values     (values),
    .fallback   (fallback)
`ifdef LFSR_SEED_LOAD_EN
    ,
    .seed_load  (seed_load),
    .seed_value (seed_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic        fb;
    logic [15:0] n;
    fb = ~(^(s & M_MASK));
    n  = {fb, s[15:1]};
    if (n == 16'hFFFF) n = M_SEED;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden rejection sampler: advances the model LFSR exactly as many draws as the DUT should.
  task automatic push_expect(input logic [11:0] lim);
    exp_t        e;
    logic [3:0]  c;
    logic [3:0]  l;
    int          tries;
    e.vals  = '0;
    e.fb    = '0;
    e.draws = 0;
    for (int ch = 0; ch < 3; ch++) begin
      tries = 0;
      l = lim[ch*4 +: 4];
      forever begin
        m_lfsr = model_step(m_lfsr);
        e.draws++;
        c = m_lfsr[3:0];
        if (c <= l) begin
          e.vals[ch*4 +: 4] = c;
          break;
        end else if (tries == 7) begin
          e.vals[ch*4 +: 4] = 4'd0;
          e.fb[ch] = 1'b1;
          break;
        end
        tries++;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic start_req(input logic [11:0] lim);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    limit      = lim;
    last_limit = lim;
    req_valid  = 1'b1;
    push_expect(lim);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    limit     = 12'($urandom);
  endtask

  task automatic wait_and_check(output exp_t e);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) chk("req_ready_busy", req_ready, 0);
    end
    e = sb_q.pop_front();
    chk("out_latency", lat, e.draws);
    chk("values", values, e.vals);
    chk("fallback", fallback, e.fb);
    $display("req limit=%03h draws=%0d values=%03h fallback=%03b", last_limit, lat, values, fallback);
  endtask

  task automatic finish_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    exp_t e;
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    limit     = '0;
    m_lfsr    = M_SEED;
`ifdef LFSR_SEED_LOAD_EN
    seed_load  = 1'b0;
    seed_value = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_values", values, 0);
    chk("rst_fallback", fallback, 0);
    @(negedge clk);
    reset = 1'b1;

    // All-ones limit: every candidate accepted, best-case latency.
    start_req(12'hFFF);
    wait_and_check(e);
    first_vals = e.vals;
    finish_out();

    // Zero limit: mostly fallbacks, worst-case latency unless a zero candidate appears.
    start_req(12'h000);
    wait_and_check(e);
    finish_out();

    // Mixed limits.
    start_req(12'hF31);
    wait_and_check(e);
    chk("ch0_in_limit", values[3:0] <= 4'h1, 1);
    chk("ch1_in_limit", values[7:4] <= 4'h3, 1);
    finish_out();

    // Backpressure in DONE with a stray request pulse.
    start_req(12'h7A5);
    wait_and_check(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = (i == 3);
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_values", values, e.vals);
      chk("bp_fallback", fallback, e.fb);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    finish_out();

    // Reset during the second DRAW cycle.
    start_req(12'hFFF);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_values", values, 0);
    chk("abort_fallback", fallback, 0);
    sb_q.delete();
    m_lfsr = M_SEED;
    @(negedge clk);
    reset = 1'b1;
    start_req(12'hFFF);
    wait_and_check(e);
    chk("replay_first", values, first_vals);
    finish_out();

`ifdef LFSR_SEED_LOAD_EN
    // Loading all-ones must land on SEED.
    @(negedge clk);
    seed_load  = 1'b1;
    seed_value = 16'hFFFF;
    #1;
    chk("seed_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    m_lfsr    = M_SEED;
    start_req(12'hFFF);
    wait_and_check(e);
    finish_out();

    // seed_load wins over a same-cycle request.
    @(negedge clk);
    seed_load  = 1'b1;
    seed_value = 16'h1234;
    req_valid  = 1'b1;
    limit      = 12'hFFF;
    #1;
    chk("seed_vs_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    req_valid = 1'b0;
    chk("seed_req_not_taken", out_valid, 0);
    chk("seed_still_idle", req_ready, 1);
    m_lfsr = 16'h1234;
    start_req(12'hF31);
    wait_and_check(e);
    finish_out();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
